// File: rtl/s386_tb_pkg.sv
// Shared types and constants for the s386 response compactor: FSM states,
// default MISR polynomial/seed and a reference signature-update function.
package s386_tb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] POLY_DEF = 16'h8005;
  localparam logic [15:0] SEED_DEF = 16'h0000;

  // One MISR step at the default widths: shift left, Galois feedback, fold in resp.
  function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [6:0] resp);
    return {sig[14:0], 1'b0} ^ (sig[15] ? POLY_DEF : 16'h0000) ^ {9'b0, resp};
  endfunction

endpackage

// File: rtl/s386_resp_misr_if.sv
// Control/response bundle between the s386 response source and the compactor.
interface s386_resp_misr_if #(
  parameter int unsigned RESP_W = 7,
  parameter int unsigned SIG_W  = 16,
  parameter int unsigned CNT_W  = 16
);
  logic              start;
  logic [CNT_W-1:0]  num_cycles;
  logic [SIG_W-1:0]  golden;
  logic [RESP_W-1:0] resp;
  logic              resp_valid;
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic [SIG_W-1:0]  signature;
  logic [CNT_W-1:0]  count;

  modport master (
    output start, num_cycles, golden, resp, resp_valid,
    input  busy, done, pass, fail, signature, count
  );

  modport slave (
    input  start, num_cycles, golden, resp, resp_valid,
    output busy, done, pass, fail, signature, count
  );
endinterface

// File: rtl/misr_core.sv
// Signature register of the s386 response MISR: reset/load to seed, step when enabled.
module misr_core #(
  parameter int unsigned RESP_W = 7,
  parameter int unsigned SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h8005
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              load,
  input  logic [SIG_W-1:0]  seed,
  input  logic              en,
  input  logic [RESP_W-1:0] resp,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] sig_next;

  always_comb begin
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(resp);
  end

  always_ff @(posedge CK) begin
    if (RST || load) begin
      sig <= seed;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/s386_resp_misr.sv
// s386 response compactor: windowed MISR over the primary outputs with a
// golden-signature compare at the end of each window.
module s386_resp_misr
  import s386_tb_pkg::*;
#(
  parameter int unsigned RESP_W = 7,
  parameter int unsigned SIG_W  = 16,
  parameter int unsigned CNT_W  = 16,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED = SIG_W'(SEED_DEF)
) (
  input  logic               CK,
  input  logic               RST,
  s386_resp_misr_if.slave    bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_lat;
  logic [SIG_W-1:0] g_lat;
  logic [SIG_W-1:0] sig;
  logic             pass_q;
  logic             fail_q;
  logic             done_q;
  logic             accept;
  logic             step;

  assign accept = bus.start && ((state == IDLE) || (state == DONE));
  assign step   = bus.resp_valid && (state == RUN);

  misr_core #(
    .RESP_W (RESP_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY)
  ) u_core (
    .CK   (CK),
    .RST  (RST),
    .load (accept),
    .seed (SEED),
    .en   (step),
    .resp (bus.resp),
    .sig  (sig)
  );

  always_ff @(posedge CK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      n_lat  <= '0;
      g_lat  <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            cnt    <= '0;
            n_lat  <= bus.num_cycles;
            g_lat  <= bus.golden;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            state  <= (bus.num_cycles != '0) ? RUN : CHECK;
          end
        end
        RUN: begin
          if (bus.resp_valid) begin
            cnt <= cnt + CNT_W'(1);
            // Compare against the pre-increment count so count never wraps in-window.
            if (cnt == n_lat - CNT_W'(1)) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          pass_q <= (sig == g_lat);
          fail_q <= (sig != g_lat);
          done_q <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == RUN) || (state == CHECK);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.signature = sig;
  assign bus.count     = cnt;

endmodule

// File: tb/tb_s386_resp_misr.sv
// Scoreboard bench for s386_resp_misr: stimulus pushes expected window results,
// a negedge monitor pops and compares them whenever done pulses.
module tb_s386_resp_misr;
  import s386_tb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  s386_resp_misr_if #(.RESP_W(7), .SIG_W(16), .CNT_W(16)) bus ();

  s386_resp_misr #(
    .RESP_W (7),
    .SIG_W  (16),
    .CNT_W  (16),
    .POLY   (16'h8005),
    .SEED   (16'h0000)
  ) dut (
    .CK  (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] sig;
    logic        pass;
    logic        fail;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   chk = 0;
  int   err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    chk++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Signature as polynomial arithmetic: multiply by x, reduce mod x^16+POLY, add the response.
  function automatic logic [15:0] ref_window(input logic [6:0] rs[$]);
    int unsigned v;
    v = 0;
    foreach (rs[i]) begin
      v = v * 2;
      if (v >= 65536) v = (v - 65536) ^ 32'h8005;
      v = v ^ 32'(rs[i]);
    end
    return v[15:0];
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        chk++;
        err++;
        $display("FAIL unexpected_done: got done=1 want no pending window");
      end else begin
        e = sb.pop_front();
        check("sb_signature", bus.signature, e.sig);
        check("sb_pass", bus.pass, e.pass);
        check("sb_fail", bus.fail, e.fail);
        check("sb_count", bus.count, e.cnt);
      end
    end
  end

  // Runs one window; vp is a valid pattern (valid=1 once exhausted), inject_at
  // pulses a competing start while busy after that many accepted responses.
  task automatic run_window(input logic [15:0] n, input logic [6:0] rs[$], input bit vp[$],
                            input logic [15:0] gold, input int inject_at,
                            output int unsigned cl[$]);
    logic [15:0] s;
    int unsigned acc;
    int unsigned p;
    int unsigned k;
    bit          inj;
    s   = ref_window(rs);
    acc = 0;
    p   = 0;
    inj = 0;
    cl  = {};
    sb.push_back('{sig: s, pass: (s == gold), fail: (s != gold), cnt: n});
    bus.start      = 1'b1;
    bus.num_cycles = n;
    bus.golden     = gold;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.num_cycles = 16'($urandom);
    bus.golden     = 16'($urandom);
    check("busy_after_start", bus.busy, 1);
    while (acc < 32'(n)) begin
      if (inject_at >= 0 && acc == 32'(inject_at) && !inj) begin
        inj            = 1;
        bus.start      = 1'b1;
        bus.num_cycles = 16'd1;
        bus.golden     = ~gold;
        bus.resp_valid = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        check("count_hold_busy_start", bus.count, acc);
        continue;
      end
      bus.resp_valid = (p < vp.size()) ? vp[p] : 1'b1;
      p++;
      bus.resp = bus.resp_valid ? rs[acc] : 7'($urandom);
      @(negedge clk);
      if (bus.resp_valid) acc++;
      cl.push_back(32'(bus.count));
    end
    bus.resp_valid = 1'b0;
    bus.resp       = 7'($urandom);
    k = 1;
    while (!bus.done && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("done_latency", k, 2);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [6:0]  rs[$];
    bit          vp[$];
    int unsigned cl[$];
    logic [15:0] n;
    logic [15:0] g;
    bus.start      = 1'b0;
    bus.num_cycles = '0;
    bus.golden     = '0;
    bus.resp       = '0;
    bus.resp_valid = 1'b0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pass", bus.pass, 0);
    check("rst_fail", bus.fail, 0);
    check("rst_signature", bus.signature, 16'h0000);
    check("rst_count", bus.count, 0);
    rst = 1'b0;
    @(negedge clk);

    rs = {7'h01};
    vp = {};
    run_window(16'd1, rs, vp, 16'h0001, -1, cl);
    check("single_sig", bus.signature, 16'h0001);
    check("single_pass", bus.pass, 1);

    rs = {7'h01, 7'h00};
    run_window(16'd2, rs, vp, 16'h0003, -1, cl);
    check("shift_sig", bus.signature, 16'h0002);
    check("shift_fail", bus.fail, 1);

    rs = {7'h01};
    for (int i = 0; i < 16; i++) rs.push_back(7'h00);
    run_window(16'd17, rs, vp, 16'h8005, -1, cl);
    check("feedback_sig", bus.signature, 16'h8005);

    rs = {7'h7F, 7'h7F, 7'h7F};
    vp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_window(16'd3, rs, vp, 16'($urandom), -1, cl);
    check("stall_cnt_len", cl.size(), 6);
    if (cl.size() == 6) begin
      check("stall_cnt0", cl[0], 1);
      check("stall_cnt1", cl[1], 1);
      check("stall_cnt2", cl[2], 1);
      check("stall_cnt3", cl[3], 2);
      check("stall_cnt4", cl[4], 2);
      check("stall_cnt5", cl[5], 3);
    end
    check("stall_sig", bus.signature, 16'h017D);

    rs = {};
    vp = {};
    run_window(16'd0, rs, vp, 16'h0000, -1, cl);
    check("zero_pass", bus.pass, 1);
    check("zero_sig", bus.signature, 16'h0000);

    // Mid-window reset: no expected entry, so any done pulse is flagged.
    bus.start      = 1'b1;
    bus.num_cycles = 16'd10;
    bus.golden     = 16'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.resp_valid = 1'b1;
      bus.resp       = 7'($urandom);
      @(negedge clk);
    end
    bus.resp_valid = 1'b0;
    check("mid_count_before_rst", bus.count, 5);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_sig", bus.signature, 16'h0000);
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_pass", bus.pass, 0);
    check("mid_rst_fail", bus.fail, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rst_idle", bus.busy, 0);

    rs = {};
    for (int i = 0; i < 10; i++) rs.push_back(7'($urandom));
    run_window(16'd10, rs, vp, ref_window(rs), -1, cl);

    rs = {};
    for (int i = 0; i < 4; i++) rs.push_back(7'($urandom));
    run_window(16'd4, rs, vp, ref_window(rs), 2, cl);
    check("busy_start_pass", bus.pass, 1);

    for (int w = 0; w < 10; w++) begin
      n  = 16'($urandom_range(1, 12));
      rs = {};
      vp = {};
      for (int i = 0; i < int'(n); i++) rs.push_back(7'($urandom));
      for (int i = 0; i < 2 * int'(n); i++) vp.push_back($urandom_range(0, 9) >= 3);
      g = ($urandom_range(0, 1) == 1) ? ref_window(rs) : 16'($urandom);
      run_window(n, rs, vp, g, ($urandom_range(0, 3) == 0) ? 1 : -1, cl);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
